mem_arbiter: RTL and testbench

- Memory-side responder to the CPU request unit.
- Accepts instruction-fetch and data load/store requests (imemRen, dmmRen, dmmWen plus addresses and store data) and serialises them onto one single-ported memory bus with a req/ack handshake.
- Returns i_ready/d_ready completion pulses with load data.
- Sits between request_unit and the SRAM/bus wrapper.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU instruction-fetch and data load/store requests
//   onto a single-ported memory bus using a req/ack handshake.
// Latency: request sampled in IDLE -> bus_req next cycle; ack -> ready next cycle (min 2 cycles).
// Backpressure: the bus stalls via a late bus_ack; the CPU side holds its level request until ready.
//
// Ports:
//   CLK, nRST          clock (rising edge), synchronous active-low reset
//   imemRen/imemaddr   instruction fetch request; imemload/i_ready return the result
//   dmmRen/dmmWen      data read/write request with dmmaddr/dmmstore; dmmload/d_ready return the result
//   bus_req/bus_we     bus transaction request and direction, held until bus_ack
//   bus_addr/bus_wdata latched transaction address and write data
//   bus_rdata/bus_ack  memory read data and one-cycle completion
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemRen,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic [DATA_W-1:0] imemload,
  output logic              i_ready,
  input  logic              dmmRen,
  input  logic              dmmWen,
  input  logic [ADDR_W-1:0] dmmaddr,
  input  logic [DATA_W-1:0] dmmstore,
  output logic [DATA_W-1:0] dmmload,
  output logic              d_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GR_INSTR = 1'b0,
    GR_DATA  = 1'b1
  } grant_t;

  state_t state, state_nx;
  grant_t last_grant, last_grant_nx;

  logic              bus_req_nx;
  logic              bus_we_nx;
  logic [ADDR_W-1:0] bus_addr_nx;
  logic [DATA_W-1:0] bus_wdata_nx;
  logic              i_ready_nx;
  logic              d_ready_nx;
  logic [DATA_W-1:0] imemload_nx;
  logic [DATA_W-1:0] dmmload_nx;

  logic data_pend;
  logic grant_data;

  assign data_pend = dmmRen | dmmWen;
  // With both ports pending, serve the one that did not win last time so
  // neither can starve; otherwise serve whichever is pending.
  assign grant_data = data_pend & (~imemRen | (last_grant == GR_INSTR));

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      last_grant <= GR_INSTR;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      imemload   <= '0;
      dmmload    <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      bus_req    <= bus_req_nx;
      bus_we     <= bus_we_nx;
      bus_addr   <= bus_addr_nx;
      bus_wdata  <= bus_wdata_nx;
      i_ready    <= i_ready_nx;
      d_ready    <= d_ready_nx;
      imemload   <= imemload_nx;
      dmmload    <= dmmload_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    bus_req_nx    = bus_req;
    bus_we_nx     = bus_we;
    bus_addr_nx   = bus_addr;
    bus_wdata_nx  = bus_wdata;
    i_ready_nx    = 1'b0;
    d_ready_nx    = 1'b0;
    imemload_nx   = imemload;
    dmmload_nx    = dmmload;

    case (state)
      IDLE: begin
        if (grant_data) begin
          bus_req_nx    = 1'b1;
          // A simultaneous read+write request is issued as a write.
          bus_we_nx     = dmmWen;
          bus_addr_nx   = dmmaddr;
          bus_wdata_nx  = dmmstore;
          last_grant_nx = GR_DATA;
          state_nx      = DBUSY;
        end else if (imemRen) begin
          bus_req_nx    = 1'b1;
          bus_we_nx     = 1'b0;
          bus_addr_nx   = imemaddr;
          last_grant_nx = GR_INSTR;
          state_nx      = IBUSY;
        end
      end
      IBUSY: begin
        if (bus_ack) begin
          bus_req_nx  = 1'b0;
          bus_we_nx   = 1'b0;
          i_ready_nx  = 1'b1;
          imemload_nx = bus_rdata;
          state_nx    = RESP;
        end
      end
      DBUSY: begin
        if (bus_ack) begin
          bus_req_nx = 1'b0;
          bus_we_nx  = 1'b0;
          d_ready_nx = 1'b1;
          if (!bus_we) dmmload_nx = bus_rdata;
          state_nx   = RESP;
        end
      end
      // One dead cycle so the requester's registered deassert lands before
      // the next arbitration.
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single-port transactions plus hand-written
// sequences for alternation, reset mid-transaction and stray acks.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemRen;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        i_ready;
  logic        dmmRen;
  logic        dmmWen;
  logic [31:0] dmmaddr;
  logic [31:0] dmmstore;
  logic [31:0] dmmload;
  logic        d_ready;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemRen(imemRen), .imemaddr(imemaddr), .imemload(imemload), .i_ready(i_ready),
    .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
    .dmmload(dmmload), .d_ready(d_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic        is_d;      // 1 = data port, 0 = fetch port
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          w;         // cycles bus_req is held before ack
    logic [31:0] rdata;
    logic        chg;       // change CPU address while busy
    logic [31:0] chg_addr;
    logic        exp_we;
    logic [31:0] exp_load;  // expected load output of that port after completion
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},    {31'd0, bus_req}, 32'd0);
    chk({tag, "_we"},     {31'd0, bus_we},  32'd0);
    chk({tag, "_addr"},   bus_addr,  32'd0);
    chk({tag, "_wdata"},  bus_wdata, 32'd0);
    chk({tag, "_irdy"},   {31'd0, i_ready}, 32'd0);
    chk({tag, "_drdy"},   {31'd0, d_ready}, 32'd0);
    chk({tag, "_iload"},  imemload,  32'd0);
    chk({tag, "_dload"},  dmmload,   32'd0);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus_req !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_req_seen"}, {31'd0, bus_req}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    imemRen = 1'b0; dmmRen = 1'b0; dmmWen = 1'b0; bus_ack = 1'b0;
    repeat (2) @(negedge CLK);
    chk_reset_outs("rst");
    nRST = 1'b1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    @(negedge CLK);
    if (v.is_d) begin
      dmmRen = v.ren; dmmWen = v.wen; dmmaddr = v.addr; dmmstore = v.wdata;
    end else begin
      imemRen = 1'b1; imemaddr = v.addr;
    end
    wait_req(tag);
    chk({tag, "_we"},   {31'd0, bus_we}, {31'd0, v.exp_we});
    chk({tag, "_addr"}, bus_addr, v.addr);
    if (v.is_d) chk({tag, "_wdata"}, bus_wdata, v.wdata);
    if (v.chg) begin
      dmmaddr = v.chg_addr;
      dmmstore = ~v.wdata;
    end
    for (int i = 0; i < v.w; i++) begin
      @(negedge CLK);
      chk({tag, "_hold_req"},  {31'd0, bus_req}, 32'd1);
      chk({tag, "_hold_addr"}, bus_addr, v.addr);
      chk({tag, "_hold_we"},   {31'd0, bus_we}, {31'd0, v.exp_we});
      if (v.is_d) chk({tag, "_hold_wdata"}, bus_wdata, v.wdata);
    end
    bus_ack = 1'b1; bus_rdata = v.rdata;
    @(negedge CLK);
    bus_ack = 1'b0;
    chk({tag, "_irdy"}, {31'd0, i_ready}, {31'd0, ~v.is_d});
    chk({tag, "_drdy"}, {31'd0, d_ready}, {31'd0, v.is_d});
    chk({tag, "_req_drop"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_load"}, v.is_d ? dmmload : imemload, v.exp_load);
    imemRen = 1'b0; dmmRen = 1'b0; dmmWen = 1'b0;
    @(negedge CLK);
    chk({tag, "_rdy_pulse"}, {30'd0, i_ready, d_ready}, 32'd0);
    chk({tag, "_load_hold"}, v.is_d ? dmmload : imemload, v.exp_load);
  endtask

  initial begin
    logic [31:0] dsave, isave;
    nRST = 1'b0;
    imemRen = 1'b0; imemaddr = '0;
    dmmRen = 1'b0; dmmWen = 1'b0; dmmaddr = '0; dmmstore = '0;
    bus_rdata = '0; bus_ack = 1'b0;

    //          is_d  ren   wen   addr          wdata         w  rdata         chg   chg_addr      we    exp_load
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,       0, 32'h0050_0093, 1'b0, 32'h0,        1'b0, 32'h0050_0093};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_2004, 32'hDEADBEEF, 5, 32'h1111_1111, 1'b0, 32'h0,        1'b1, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_2008, 32'h0,       1, 32'hCAFE_F00D, 1'b0, 32'h0,        1'b0, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, 2, 32'h2222_2222, 1'b1, 32'h0000_3000, 1'b1, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h0,       3, 32'h00A0_0113, 1'b0, 32'h0,        1'b0, 32'h00A0_0113};

    repeat (3) @(negedge CLK);
    chk_reset_outs("init");
    nRST = 1'b1;

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Alternation: both ports pending after reset -> D, I, D, I.
    do_reset();
    @(negedge CLK);
    imemRen = 1'b1; imemaddr = 32'h0000_0200;
    dmmRen = 1'b1; dmmaddr = 32'h0000_0300;
    for (int g = 0; g < 4; g++) begin
      string tag;
      logic  exp_d;
      tag = $sformatf("alt%0d", g);
      exp_d = (g % 2 == 0);
      wait_req(tag);
      chk({tag, "_addr"}, bus_addr, exp_d ? 32'h300 : 32'h200);
      chk({tag, "_we"}, {31'd0, bus_we}, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'hA0 + g;
      @(negedge CLK);
      bus_ack = 1'b0;
      chk({tag, "_rdy"}, {30'd0, i_ready, d_ready}, exp_d ? 32'd1 : 32'd2);
      chk({tag, "_load"}, exp_d ? dmmload : imemload, 32'hA0 + g);
      chk({tag, "_resp_req"}, {31'd0, bus_req}, 32'd0);
      @(negedge CLK);
      chk({tag, "_idle_rdy"}, {30'd0, i_ready, d_ready}, 32'd0);
      chk({tag, "_idle_req"}, {31'd0, bus_req}, 32'd0);
    end
    imemRen = 1'b0; dmmRen = 1'b0;
    @(negedge CLK);
    @(negedge CLK);

    // Reset during IBUSY, then a stray ack after reset is released.
    imemRen = 1'b1; imemaddr = 32'h0000_0400;
    wait_req("rmid");
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    chk_reset_outs("rmid");
    nRST = 1'b1; imemRen = 1'b0;
    @(negedge CLK);
    bus_ack = 1'b1; bus_rdata = 32'hBAD0_0001;
    @(negedge CLK);
    bus_ack = 1'b0;
    chk("rmid_no_irdy", {30'd0, i_ready, d_ready}, 32'd0);
    chk("rmid_no_req", {31'd0, bus_req}, 32'd0);
    chk("rmid_iload", imemload, 32'd0);

    // Stray ack in IDLE with nothing pending.
    vecs[0].rdata = 32'h0000_0AAA; vecs[0].exp_load = 32'h0000_0AAA;
    run_txn(vecs[0], "pre");
    isave = imemload; dsave = dmmload;
    bus_ack = 1'b1; bus_rdata = 32'hBAD0_0002;
    @(negedge CLK);
    bus_ack = 1'b0;
    @(negedge CLK);
    chk("idle_ack_rdy", {30'd0, i_ready, d_ready}, 32'd0);
    chk("idle_ack_req", {31'd0, bus_req}, 32'd0);
    chk("idle_ack_iload", imemload, isave);
    chk("idle_ack_dload", dmmload, dsave);

    // Stray ack in RESP: data read completes, then ack pulsed in the RESP cycle.
    dmmRen = 1'b1; dmmaddr = 32'h0000_0500;
    wait_req("resp");
    bus_ack = 1'b1; bus_rdata = 32'h0000_0BBB;
    @(negedge CLK);
    chk("resp_drdy", {31'd0, d_ready}, 32'd1);
    dmmRen = 1'b0;
    bus_rdata = 32'hBAD0_0003;   // ack still high through RESP
    @(negedge CLK);
    bus_ack = 1'b0;
    chk("resp_ack_rdy", {30'd0, i_ready, d_ready}, 32'd0);
    chk("resp_ack_req", {31'd0, bus_req}, 32'd0);
    chk("resp_ack_dload", dmmload, 32'h0000_0BBB);
    chk("resp_ack_iload", imemload, isave);

    // Arbiter must still be in IDLE and serve a fresh write normally.
    vecs[1].w = 0; vecs[1].exp_load = 32'h0000_0BBB;
    run_txn(vecs[1], "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
